// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types used by the fetch stage.
//   word_t         32-bit machine word
//   fetch_state_t  fetch FSM states
//   fetch_entry_t  {instr, pc, npc} record held by the output latch and the skid
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FS_FETCH,
    FS_SKID,
    FS_HALT
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
  } fetch_entry_t;

  function automatic fetch_entry_t mk_entry(word_t instr, word_t pc, word_t npc);
    fetch_entry_t e;
    e.instr = instr;
    e.pc    = pc;
    e.npc   = npc;
    return e;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between the program counter and decode.
// Reads imem at PC, hands {instr, pc, npc} to decode through a valid/ready latch backed by a
// one-entry skid, and is the only source of the PC load (sequential advance or flush redirect).
//
// Ports
//   CLK, nRST             clock, asynchronous active-low reset
//   PC, npc               current PC and PC+4 from the program counter
//   PCEN, new_pc          PC load enable and load value
//   imemREN, imemaddr     imem read request and address (= PC)
//   imemload, ihit        imem read data, valid when ihit=1
//   flush, redirect_pc    taken branch/jump from execute and its target
//   halt                  stop fetching (sticky until reset)
//   id_ready              decode consumes the latch this cycle
//   if_valid, instr_o,
//   pc_o, npc_o           latch contents presented to decode
//   fetch_cnt, stall_cnt  performance counters (only with FETCH_PERF_CNT_EN)
//
// Build option: define FETCH_PERF_CNT_EN to add the fetch/stall performance counters.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t       NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] PC,
  input  logic [31:0] npc,
  output logic        PCEN,
  output logic [31:0] new_pc,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic [31:0] imemload,
  input  logic        ihit,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic [31:0] npc_o
);

  fetch_state_t state_q, state_d;
  fetch_entry_t latch_q, latch_d;
  fetch_entry_t skid_q, skid_d;
  logic         valid_q, valid_d;
  logic         skid_vld_q, skid_vld_d;

  logic         pcen_c;
  logic         ren_c;
  word_t        new_pc_c;
  logic         accept;
  logic         load;     // latch written this cycle (fresh fetch or from skid)
  fetch_entry_t fetched;

  assign accept  = ~valid_q | id_ready;
  assign fetched = mk_entry(imemload, PC, npc);

  always_comb begin
    state_d    = state_q;
    latch_d    = latch_q;
    valid_d    = valid_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    pcen_c     = 1'b0;
    ren_c      = 1'b0;
    new_pc_c   = npc;
    load       = 1'b0;

    // Decode taking the latch empties it unless something is written below.
    if (id_ready) valid_d = 1'b0;

    case (state_q)
      FS_FETCH: begin
        ren_c = 1'b1;
        if (flush) begin
          // The in-flight read for the old PC still completes; its data is dropped.
          pcen_c     = 1'b1;
          new_pc_c   = redirect_pc;
          valid_d    = 1'b0;
          skid_vld_d = 1'b0;
        end else if (halt) begin
          ren_c   = 1'b0;
          state_d = FS_HALT;
        end else if (ihit) begin
          pcen_c   = 1'b1;
          new_pc_c = npc;
          if (accept) begin
            latch_d = fetched;
            valid_d = 1'b1;
            load    = 1'b1;
          end else begin
            skid_d     = fetched;
            skid_vld_d = 1'b1;
            state_d    = FS_SKID;
          end
        end
      end

      FS_SKID: begin
        if (flush) begin
          pcen_c     = 1'b1;
          new_pc_c   = redirect_pc;
          valid_d    = 1'b0;
          skid_vld_d = 1'b0;
          state_d    = FS_FETCH;
        end else begin
          if (halt) state_d = FS_HALT;
          if (id_ready) begin
            latch_d    = skid_q;
            valid_d    = 1'b1;
            skid_vld_d = 1'b0;
            load       = 1'b1;
            if (!halt) state_d = FS_FETCH;
          end
        end
      end

      FS_HALT: begin
        // No fetching and no redirects; only whatever is buffered drains to decode.
        if (id_ready && skid_vld_q) begin
          latch_d    = skid_q;
          valid_d    = 1'b1;
          skid_vld_d = 1'b0;
          load       = 1'b1;
        end
      end

      default: state_d = FS_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= FS_FETCH;
      latch_q    <= mk_entry(NOP_INSTR, 32'h0, 32'h0);
      valid_q    <= 1'b0;
      skid_q     <= mk_entry(NOP_INSTR, 32'h0, 32'h0);
      skid_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      latch_q    <= latch_d;
      valid_q    <= valid_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // Requests are gated by reset so the PC and cache see nothing while nRST is low.
  assign PCEN     = pcen_c & nRST;
  assign imemREN  = ren_c & nRST;
  assign new_pc   = new_pc_c;
  assign imemaddr = PC;

  assign if_valid = valid_q;
  assign instr_o  = valid_q ? latch_q.instr : NOP_INSTR;
  assign pc_o     = latch_q.pc;
  assign npc_o    = latch_q.npc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if (state_q != FS_HALT) begin
      if (load) fetch_cnt <= fetch_cnt + 1'b1;
      if (ren_c && !ihit) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of the fetch stage scenarios plus a randomized run against a
// program-order reference model. The bench plays the program counter and the instruction
// memory; every instruction handed to decode must be the next one in program order, where a
// flush restarts program order at the redirect target.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  localparam word_t NOP = 32'h0000_0013;
  localparam int    RAND_CYCLES = 3000;
  localparam int    HALT_AT = 2700;

  logic        CLK = 1'b0;
  logic        nRST;
  word_t       pc_reg;
  word_t       npc;
  logic        PCEN;
  word_t       new_pc;
  logic        imemREN;
  word_t       imemaddr;
  word_t       imemload;
  logic        ihit;
  logic        flush;
  word_t       redirect_pc;
  logic        halt;
  logic        id_ready;
  logic        if_valid;
  word_t       instr_o;
  word_t       pc_o;
  word_t       npc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad = 0;
  int delivered = 0;

  fetch_entry_t exp_q[$];
  word_t        prog_ptr;
  logic         halted_m;
  logic         mon_en = 1'b0;

  always #5 CLK = ~CLK;

  fetch_unit #(
    .NOP_INSTR(NOP),
    .CNT_W    (32)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .PC         (pc_reg),
    .npc        (npc),
    .PCEN       (PCEN),
    .new_pc     (new_pc),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .imemload   (imemload),
    .ihit       (ihit),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .id_ready   (id_ready),
    .if_valid   (if_valid),
    .instr_o    (instr_o),
    .pc_o       (pc_o),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .npc_o      (npc_o)
  );

  // Instruction memory contents: one fixed word, everything else a hash of the address.
  function automatic word_t imem_word(word_t a);
    if (a == 32'h0000_0010) return 32'h2008_0001;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Program counter register owned by the environment.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) pc_reg <= 32'h0;
    else if (PCEN) pc_reg <= new_pc;
  end
  assign npc      = pc_reg + 32'd4;
  assign imemload = imem_word(pc_reg);

  task automatic check(input string name, input word_t got, input word_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then let outputs settle.
  task automatic step(input logic ih, input logic rdy, input logic fl, input word_t rpc,
                      input logic ht);
    @(negedge CLK);
    ihit        = ih;
    id_ready    = rdy;
    flush       = fl;
    redirect_pc = rpc;
    halt        = ht;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    ihit = 1'b0; id_ready = 1'b0; flush = 1'b0; halt = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Latch holds PC 0x0C and the fetch of PC 0x10 lands in the skid.
  task automatic to_skid();
    do_reset();
    step(1'b0, 1'b0, 1'b1, 32'h0000_000C, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic topup();
    while (exp_q.size() < 4) begin
      exp_q.push_back(mk_entry(imem_word(prog_ptr), prog_ptr, prog_ptr + 32'd4));
      prog_ptr = prog_ptr + 32'd4;
    end
  endtask

  // Monitor: pops the expected program-order entry on every decode handshake.
  always @(negedge CLK) begin
    if (mon_en) begin
      fetch_entry_t e;
      #2;
      check("imemaddr_eq_pc", imemaddr, pc_reg);
      if (halted_m) begin
        check1("halted_pcen", PCEN, 1'b0);
        check1("halted_ren", imemREN, 1'b0);
      end else if (flush) begin
        check1("flush_pcen", PCEN, 1'b1);
        check("flush_new_pc", new_pc, redirect_pc);
      end else if (halt) begin
        check1("halt_pcen", PCEN, 1'b0);
        check1("halt_ren", imemREN, 1'b0);
      end else if (PCEN) begin
        check("seq_new_pc", new_pc, pc_reg + 32'd4);
      end
      if (!if_valid) check("idle_instr", instr_o, NOP);
      if (if_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL deliver_unexpected: got pc %h expected nothing", pc_o);
        end else begin
          e = exp_q.pop_front();
          check("deliver_instr", instr_o, e.instr);
          check("deliver_pc", pc_o, e.pc);
          check("deliver_npc", npc_o, e.npc);
          delivered++;
        end
      end
    end
  end

  initial begin
    nRST = 1'b0;
    ihit = 1'b0; id_ready = 1'b0; flush = 1'b0; halt = 1'b0; redirect_pc = 32'h0;
    halted_m = 1'b0;
    prog_ptr = 32'h0;

    // Reset state; requests stay off even with a hit pending.
    @(negedge CLK);
    ihit = 1'b1;
    #1;
    check1("rst_if_valid", if_valid, 1'b0);
    check("rst_instr", instr_o, NOP);
    check("rst_pc_o", pc_o, 32'h0);
    check("rst_npc_o", npc_o, 32'h0);
    check1("rst_pcen", PCEN, 1'b0);
    check1("rst_ren", imemREN, 1'b0);

    // Streaming: one instruction per cycle, one-cycle latency.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check1("stream_pcen0", PCEN, 1'b1);
    check1("stream_valid0", if_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      check1("stream_pcen", PCEN, 1'b1);
      check1("stream_valid", if_valid, 1'b1);
      check("stream_pc_o", pc_o, 32'(i * 4));
      check("stream_instr", instr_o, imem_word(32'(i * 4)));
    end

    // Backpressure through the skid.
    to_skid();
    check("bp_addr", imemaddr, 32'h0000_0010);
    check1("bp_pcen", PCEN, 1'b1);
    check("bp_new_pc", new_pc, 32'h0000_0014);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check1("skid_ren", imemREN, 1'b0);
    check1("skid_pcen", PCEN, 1'b0);
    check("skid_latch_pc", pc_o, 32'h0000_000C);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("bp_instr", instr_o, 32'h2008_0001);
    check("bp_pc_o", pc_o, 32'h0000_0010);
    check("bp_npc_o", npc_o, 32'h0000_0014);
    check1("bp_back_fetch", imemREN, 1'b1);

    // Asynchronous reset while in the skid state.
    to_skid();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2 nRST = 1'b0;
    #1;
    check1("arst_valid", if_valid, 1'b0);
    check1("arst_pcen", PCEN, 1'b0);
    check1("arst_ren", imemREN, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check1("arst_fetch_state", imemREN, 1'b1);

    // Flush with a simultaneous hit.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
    check1("flush_pcen_d", PCEN, 1'b1);
    check("flush_new_pc_d", new_pc, 32'h0000_0040);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check1("flush_valid_d", if_valid, 1'b0);
    check("flush_addr_d", imemaddr, 32'h0000_0040);

    // Halt with a valid latch, drain, then an ignored flush.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check1("halt_ren_d", imemREN, 1'b0);
    check1("halt_pcen_d", PCEN, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check1("halt_latch_kept", if_valid, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0);
    check1("halt_drained", if_valid, 1'b0);
    check1("halt_flush_pcen", PCEN, 1'b0);
    check1("halt_flush_ren", imemREN, 1'b0);

    // Wait states.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check1("wait_pcen", PCEN, 1'b0);
      check("wait_addr", imemaddr, 32'h0);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check1("wait_hit_pcen", PCEN, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_stall", stall_cnt, 32'd3);
    check("perf_fetch", fetch_cnt, 32'd1);
`endif

    // Randomized run against the program-order model.
    do_reset();
    exp_q.delete();
    prog_ptr = 32'h0;
    halted_m = 1'b0;
    topup();
    mon_en = 1'b1;
    for (int i = 0; i < RAND_CYCLES + 12; i++) begin
      @(negedge CLK);
      ihit        = ($urandom_range(0, 99) < 75);
      id_ready    = (i >= RAND_CYCLES) ? 1'b1 : ($urandom_range(0, 99) < 70);
      flush       = ($urandom_range(0, 99) < 3);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      halt        = (i == HALT_AT);
      #3;
      if (flush && !halted_m) begin
        exp_q.delete();
        prog_ptr = redirect_pc;
      end else if (halt && !halted_m) begin
        halted_m = 1'b1;
      end
      topup();
    end
    @(negedge CLK);
    mon_en = 1'b0;
    #3;
    check1("final_drained", if_valid, 1'b0);
    check1("enough_delivered", delivered >= 500, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
